// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the nanoLADA datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM, WB and an optional
// MUL/DIV wait state. Holds memory requests until ready and issues
// single-cycle write strobes.
//
// Build option: define MULDIV_EN to route MUL/DIV through the MDWAIT state
// using the md_start/md_done handshake. When it is undefined, MUL/DIV decode
// as illegal and md_start never asserts.
//
// Handshake rule: imem_req/dmem_req are held high, with all outputs stable,
// until the matching *_ready is seen high on a rising clock edge. The
// transfer completes on that edge. md_start is a one-cycle pulse, and md_done
// is only looked at in MDWAIT.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       z_flag,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       md_done,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       mem_wr,
    output logic       md_start,
    output logic       sel_pc,
    output logic       sel_addpc,
    output logic       sel_wr,
    output logic       sel_b,
    output logic       sel_data,
    output logic [1:0] ext_ops,
    output logic [5:0] alu_ops,
    output logic       retire,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_SLT = 6'h2a;
    localparam logic [5:0] F_MUL = 6'h18;
    localparam logic [5:0] F_DIV = 6'h1a;

    state_t state_q, state_d;

    logic is_rtype, is_j, is_beq, is_bne, is_ori, is_lw, is_sw, is_md;
    logic funct_ok, legal;

    // Classify the instruction held in IR and decide whether it is legal.
    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        is_j     = (opcode == OP_J);
        is_beq   = (opcode == OP_BEQ);
        is_bne   = (opcode == OP_BNE);
        is_ori   = (opcode == OP_ORI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_md    = 1'b0;
`ifdef MULDIV_EN
        is_md    = is_rtype && ((funct == F_MUL) || (funct == F_DIV));
`endif
        funct_ok = (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT}) || is_md;
        legal    = (is_rtype && funct_ok) || is_j || is_beq || is_bne ||
                   is_ori || is_lw || is_sw;
    end

    // Datapath steering; the PC mux is pinned to PC+4 while fetching.
    always_comb begin
        alu_ops = F_ADD;
        if (is_rtype) begin
            alu_ops = funct;
        end else if (is_ori) begin
            alu_ops = F_OR;
        end else if (is_beq || is_bne) begin
            alu_ops = F_SUB;
        end
        sel_b     = is_rtype || is_beq || is_bne;
        ext_ops   = (is_lw || is_sw || is_beq || is_bne) ? 2'b01 : 2'b00;
        sel_wr    = is_rtype;
        sel_data  = is_lw;
        sel_pc    = is_j && (state_q != S_FETCH);
        sel_addpc = (is_beq || is_bne) && (state_q != S_FETCH);
    end

    // Next-state and strobe decode; reset masks every strobe in the same cycle.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        pc_wr    = 1'b0;
        ir_wr    = 1'b0;
        reg_wr   = 1'b0;
        mem_wr   = 1'b0;
        md_start = 1'b0;
        retire   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_j) begin
                    pc_wr   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_beq || is_bne) begin
                    pc_wr   = is_beq ? z_flag : !z_flag;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_md) begin
                    md_start = 1'b1;
                    state_d  = S_MDWAIT;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                mem_wr   = is_sw;
                if (dmem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_MDWAIT: begin
                if (md_done) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_wr  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            pc_wr    = 1'b0;
            ir_wr    = 1'b0;
            reg_wr   = 1'b0;
            mem_wr   = 1'b0;
            md_start = 1'b0;
            retire   = 1'b0;
            illegal  = 1'b0;
        end
    end

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Each cycle vector carries the
// inputs {reset, imem_ready, dmem_ready, z_flag, md_done} and the expected
// {state, strobes}. Inputs change 1 time unit after the rising edge, and
// outputs are sampled 3 time units later.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       z_flag;
    logic       imem_ready;
    logic       dmem_ready;
    logic       md_done;
    logic       imem_req, dmem_req, pc_wr, ir_wr, reg_wr, mem_wr, md_start;
    logic       sel_pc, sel_addpc, sel_wr, sel_b, sel_data;
    logic [1:0] ext_ops;
    logic [5:0] alu_ops;
    logic       retire, illegal;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // strobe bit positions within strb
    localparam logic [8:0] IMREQ = 9'h100;
    localparam logic [8:0] DMREQ = 9'h080;
    localparam logic [8:0] PCWR  = 9'h040;
    localparam logic [8:0] IRWR  = 9'h020;
    localparam logic [8:0] REGWR = 9'h010;
    localparam logic [8:0] MEMWR = 9'h008;
    localparam logic [8:0] MDST  = 9'h004;
    localparam logic [8:0] RET   = 9'h002;
    localparam logic [8:0] ILL   = 9'h001;
    localparam logic [8:0] FETCHED = IMREQ | PCWR | IRWR;

    // input bit positions within a vector
    localparam logic [4:0] RST = 5'h10;
    localparam logic [4:0] IR  = 5'h08;
    localparam logic [4:0] DR  = 5'h04;
    localparam logic [4:0] ZF  = 5'h02;
    localparam logic [4:0] MD  = 5'h01;

    wire [8:0]  strb  = {imem_req, dmem_req, pc_wr, ir_wr, reg_wr, mem_wr, md_start, retire, illegal};
    wire [12:0] steer = {sel_pc, sel_addpc, sel_wr, sel_b, sel_data, ext_ops, alu_ops};

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .z_flag     (z_flag),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .md_done    (md_done),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .pc_wr      (pc_wr),
        .ir_wr      (ir_wr),
        .reg_wr     (reg_wr),
        .mem_wr     (mem_wr),
        .md_start   (md_start),
        .sel_pc     (sel_pc),
        .sel_addpc  (sel_addpc),
        .sel_wr     (sel_wr),
        .sel_b      (sel_b),
        .sel_data   (sel_data),
        .ext_ops    (ext_ops),
        .alu_ops    (alu_ops),
        .retire     (retire),
        .illegal    (illegal),
        .state      (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] cyc(input logic [4:0] in, input logic [2:0] st, input logic [8:0] sb);
        return {in, st, sb};
    endfunction

    // apply one cycle of inputs and move to the sample point
    task automatic drive(input logic [4:0] in);
        {reset, imem_ready, dmem_ready, z_flag, md_done} = in;
        #3;
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] seq[$];
        tick();
        seq.push_back(cyc(RST | IR, 3'd0, 9'h000));
        seq.push_back(cyc(5'h00, 3'd0, IMREQ));
        seq.push_back(cyc(5'h00, 3'd0, IMREQ));
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i][16:12]);
            n_checks++;
            if ({state, strb} !== seq[i][11:0]) begin
                n_fail++;
                $display("FAIL reset c%0d: state/strobes got %0d/%h expected %0d/%h",
                         i, state, strb, seq[i][11:9], seq[i][8:0]);
            end
            tick();
        end
    endtask

    task automatic test_alu();
        logic [16:0] seq[$];
        int          chk_idx;
        logic [12:0] exp_steer;
        string       nm;
        for (int c = 0; c < 3; c++) begin
            seq.delete();
            case (c)
                0: begin
                    nm = "add"; opcode = 6'h00; funct = 6'h20; chk_idx = 3; exp_steer = 13'h0620;
                    seq.push_back(cyc(IR | DR | MD, 3'd0, FETCHED));
                    seq.push_back(cyc(IR | DR | MD, 3'd1, 9'h000));
                    seq.push_back(cyc(IR | DR | MD, 3'd2, 9'h000));
                    seq.push_back(cyc(IR | DR | MD, 3'd4, REGWR | RET));
                end
                1: begin
                    nm = "ori"; opcode = 6'h0d; funct = 6'h00; chk_idx = 3; exp_steer = 13'h0025;
                    seq.push_back(cyc(IR, 3'd0, FETCHED));
                    seq.push_back(cyc(5'h00, 3'd1, 9'h000));
                    seq.push_back(cyc(5'h00, 3'd2, 9'h000));
                    seq.push_back(cyc(5'h00, 3'd4, REGWR | RET));
                end
                default: begin
                    nm = "slt_istall"; opcode = 6'h00; funct = 6'h2a; chk_idx = 5; exp_steer = 13'h062a;
                    seq.push_back(cyc(5'h00, 3'd0, IMREQ));
                    seq.push_back(cyc(5'h00, 3'd0, IMREQ));
                    seq.push_back(cyc(IR, 3'd0, FETCHED));
                    seq.push_back(cyc(5'h00, 3'd1, 9'h000));
                    seq.push_back(cyc(5'h00, 3'd2, 9'h000));
                    seq.push_back(cyc(5'h00, 3'd4, REGWR | RET));
                end
            endcase
            for (int i = 0; i < seq.size(); i++) begin
                drive(seq[i][16:12]);
                n_checks++;
                if ({state, strb} !== seq[i][11:0]) begin
                    n_fail++;
                    $display("FAIL %s c%0d: state/strobes got %0d/%h expected %0d/%h",
                             nm, i, state, strb, seq[i][11:9], seq[i][8:0]);
                end
                if (i == chk_idx) begin
                    n_checks++;
                    if (steer !== exp_steer) begin
                        n_fail++;
                        $display("FAIL %s steer: got %h expected %h", nm, steer, exp_steer);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_mem();
        logic [16:0] seq[$];
        int          chk_idx;
        logic [12:0] exp_steer;
        string       nm;
        for (int c = 0; c < 3; c++) begin
            seq.delete();
            funct = 6'h00;
            case (c)
                0: begin
                    nm = "lw_dstall"; opcode = 6'h23; chk_idx = 7; exp_steer = 13'h0160;
                    seq.push_back(cyc(IR, 3'd0, FETCHED));
                    seq.push_back(cyc(5'h00, 3'd1, 9'h000));
                    seq.push_back(cyc(5'h00, 3'd2, 9'h000));
                    seq.push_back(cyc(5'h00, 3'd3, DMREQ));
                    seq.push_back(cyc(5'h00, 3'd3, DMREQ));
                    seq.push_back(cyc(5'h00, 3'd3, DMREQ));
                    seq.push_back(cyc(DR, 3'd3, DMREQ));
                    seq.push_back(cyc(5'h00, 3'd4, REGWR | RET));
                end
                1: begin
                    nm = "sw_dstall"; opcode = 6'h2b; chk_idx = 4; exp_steer = 13'h0060;
                    seq.push_back(cyc(IR, 3'd0, FETCHED));
                    seq.push_back(cyc(5'h00, 3'd1, 9'h000));
                    seq.push_back(cyc(5'h00, 3'd2, 9'h000));
                    seq.push_back(cyc(5'h00, 3'd3, DMREQ | MEMWR));
                    seq.push_back(cyc(DR, 3'd3, DMREQ | MEMWR | RET));
                end
                default: begin
                    nm = "sw_nowait"; opcode = 6'h2b; chk_idx = 3; exp_steer = 13'h0060;
                    seq.push_back(cyc(IR | DR, 3'd0, FETCHED));
                    seq.push_back(cyc(IR | DR, 3'd1, 9'h000));
                    seq.push_back(cyc(IR | DR, 3'd2, 9'h000));
                    seq.push_back(cyc(DR, 3'd3, DMREQ | MEMWR | RET));
                    seq.push_back(cyc(5'h00, 3'd0, IMREQ));
                end
            endcase
            for (int i = 0; i < seq.size(); i++) begin
                drive(seq[i][16:12]);
                n_checks++;
                if ({state, strb} !== seq[i][11:0]) begin
                    n_fail++;
                    $display("FAIL %s c%0d: state/strobes got %0d/%h expected %0d/%h",
                             nm, i, state, strb, seq[i][11:9], seq[i][8:0]);
                end
                if (i == chk_idx) begin
                    n_checks++;
                    if (steer !== exp_steer) begin
                        n_fail++;
                        $display("FAIL %s steer: got %h expected %h", nm, steer, exp_steer);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_branch();
        logic [16:0] seq[$];
        int          chk_idx;
        logic [12:0] exp_steer, mask;
        logic [4:0]  z;
        logic [8:0]  exec_sb;
        string       nm;
        for (int c = 0; c < 6; c++) begin
            seq.delete();
            funct   = 6'h00;
            chk_idx = 2;
            mask    = 13'h1fff;
            exp_steer = 13'h0a62;
            case (c)
                0: begin nm = "beq_taken";    opcode = 6'h04; z = ZF;    exec_sb = PCWR | RET; end
                1: begin nm = "beq_nottaken"; opcode = 6'h04; z = 5'h00; exec_sb = RET;        end
                2: begin nm = "bne_taken";    opcode = 6'h05; z = 5'h00; exec_sb = PCWR | RET; end
                3: begin nm = "bne_nottaken"; opcode = 6'h05; z = ZF;    exec_sb = RET;        end
                4: begin
                    nm = "j_exec"; opcode = 6'h02; z = 5'h00; exec_sb = PCWR | RET;
                    mask = 13'h1800; exp_steer = 13'h1000;
                end
                default: begin
                    nm = "j_fetch_pc4"; opcode = 6'h02; z = 5'h00; exec_sb = PCWR | RET;
                    mask = 13'h1800; exp_steer = 13'h0000; chk_idx = 0;
                end
            endcase
            seq.push_back(cyc(IR | z, 3'd0, FETCHED));
            seq.push_back(cyc(z, 3'd1, 9'h000));
            seq.push_back(cyc(z, 3'd2, exec_sb));
            for (int i = 0; i < seq.size(); i++) begin
                drive(seq[i][16:12]);
                n_checks++;
                if ({state, strb} !== seq[i][11:0]) begin
                    n_fail++;
                    $display("FAIL %s c%0d: state/strobes got %0d/%h expected %0d/%h",
                             nm, i, state, strb, seq[i][11:9], seq[i][8:0]);
                end
                if (i == chk_idx) begin
                    n_checks++;
                    if ((steer & mask) !== exp_steer) begin
                        n_fail++;
                        $display("FAIL %s steer: got %h expected %h (mask %h)", nm, steer & mask, exp_steer, mask);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_illegal();
        logic [16:0] seq[$];
        int          n_cases;
        string       nm;
`ifdef MULDIV_EN
        n_cases = 2;
`else
        n_cases = 4;
`endif
        for (int c = 0; c < n_cases; c++) begin
            seq.delete();
            case (c)
                0: begin nm = "ill_op3f";    opcode = 6'h3f; funct = 6'h20; end
                1: begin nm = "ill_funct21"; opcode = 6'h00; funct = 6'h21; end
                2: begin nm = "ill_mul";     opcode = 6'h00; funct = 6'h18; end
                default: begin nm = "ill_div"; opcode = 6'h00; funct = 6'h1a; end
            endcase
            seq.push_back(cyc(IR | DR, 3'd0, FETCHED));
            seq.push_back(cyc(DR | ZF, 3'd1, ILL));
            seq.push_back(cyc(DR, 3'd0, IMREQ));
            for (int i = 0; i < seq.size(); i++) begin
                drive(seq[i][16:12]);
                n_checks++;
                if ({state, strb} !== seq[i][11:0]) begin
                    n_fail++;
                    $display("FAIL %s c%0d: state/strobes got %0d/%h expected %0d/%h",
                             nm, i, state, strb, seq[i][11:9], seq[i][8:0]);
                end
                tick();
            end
        end
    endtask

`ifdef MULDIV_EN
    task automatic test_muldiv();
        logic [16:0] seq[$];
        string       nm;
        for (int c = 0; c < 2; c++) begin
            seq.delete();
            opcode = 6'h00;
            if (c == 0) begin nm = "mul"; funct = 6'h18; end
            else begin nm = "div"; funct = 6'h1a; end
            seq.push_back(cyc(IR | MD, 3'd0, FETCHED));
            seq.push_back(cyc(MD, 3'd1, 9'h000));
            seq.push_back(cyc(5'h00, 3'd2, MDST));
            for (int k = 0; k < 4; k++) seq.push_back(cyc(5'h00, 3'd5, 9'h000));
            seq.push_back(cyc(MD, 3'd5, 9'h000));
            seq.push_back(cyc(5'h00, 3'd4, REGWR | RET));
            for (int i = 0; i < seq.size(); i++) begin
                drive(seq[i][16:12]);
                n_checks++;
                if ({state, strb} !== seq[i][11:0]) begin
                    n_fail++;
                    $display("FAIL %s c%0d: state/strobes got %0d/%h expected %0d/%h",
                             nm, i, state, strb, seq[i][11:9], seq[i][8:0]);
                end
                tick();
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [16:0] seq[$];
        opcode = 6'h2b;
        funct  = 6'h00;
        seq.push_back(cyc(IR, 3'd0, FETCHED));
        seq.push_back(cyc(5'h00, 3'd1, 9'h000));
        seq.push_back(cyc(5'h00, 3'd2, 9'h000));
        seq.push_back(cyc(RST | DR, 3'd3, 9'h000));
        seq.push_back(cyc(5'h00, 3'd0, IMREQ));
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i][16:12]);
            n_checks++;
            if ({state, strb} !== seq[i][11:0]) begin
                n_fail++;
                $display("FAIL reset_mid_sw c%0d: state/strobes got %0d/%h expected %0d/%h",
                         i, state, strb, seq[i][11:9], seq[i][8:0]);
            end
            tick();
        end
    endtask

    initial begin
        reset      = 1'b1;
        opcode     = 6'h00;
        funct      = 6'h20;
        z_flag     = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        md_done    = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_illegal();
`ifdef MULDIV_EN
        test_muldiv();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
